// File: rtl/snake_pkg.sv
// Shared types for the snake game core: direction codes, FSM states and
// the reverse-direction helper.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_e;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_CALC,
    ST_SCAN,
    ST_UPDATE,
    ST_DEAD
  } state_e;

  // Opposite directions differ only in bit 1.
  function automatic dir_e rev_dir(input dir_e d);
    return dir_e'(d ^ 2'b10);
  endfunction

endpackage

// File: rtl/snake_next_head.sv
// Next head cell for one move; wraps on a torus or flags an edge crossing.
module snake_next_head
  import snake_pkg::*;
#(
  parameter int SIZE_X = 40,
  parameter int SIZE_Y = 30,
  parameter int WRAP   = 1,
  parameter int XW     = $clog2(SIZE_X),
  parameter int YW     = $clog2(SIZE_Y)
) (
  input  logic [XW-1:0] head_x,
  input  logic [YW-1:0] head_y,
  input  dir_e          dir,
  output logic [XW-1:0] next_x,
  output logic [YW-1:0] next_y,
  output logic          oob
);

  localparam logic [XW-1:0] X_MAX = XW'(SIZE_X - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(SIZE_Y - 1);
  localparam logic          KILL  = (WRAP == 0);

  always_comb begin
    next_x = head_x;
    next_y = head_y;
    oob    = 1'b0;
    unique case (dir)
      DIR_UP:
        if (head_y == '0) begin
          next_y = Y_MAX;
          oob    = KILL;
        end else next_y = head_y - YW'(1);
      DIR_RIGHT:
        if (head_x == X_MAX) begin
          next_x = '0;
          oob    = KILL;
        end else next_x = head_x + XW'(1);
      DIR_DOWN:
        if (head_y == Y_MAX) begin
          next_y = '0;
          oob    = KILL;
        end else next_y = head_y + YW'(1);
      DIR_LEFT:
        if (head_x == '0) begin
          next_x = X_MAX;
          oob    = KILL;
        end else next_x = head_x - XW'(1);
      default: oob = 1'b0;
    endcase
  end

endmodule

// File: rtl/snake_core.sv
// Snake body engine: circular segment store, move FSM with serial
// self-collision scan, and a registered segment read port.
module snake_core
  import snake_pkg::*;
#(
  parameter int SIZE_X   = 40,
  parameter int SIZE_Y   = 30,
  parameter int MAX_LEN  = 64,
  parameter int INIT_LEN = 3,
  parameter int WRAP     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         step,
  input  logic [1:0]                   dir,
  input  logic                         grow,
  output logic                         busy,
  output logic                         done,
  output logic                         dead,
  output logic [$clog2(MAX_LEN+1)-1:0] length,
  output logic [$clog2(SIZE_X)-1:0]    head_x,
  output logic [$clog2(SIZE_Y)-1:0]    head_y,
  output logic [1:0]                   cur_dir,
  input  logic [$clog2(MAX_LEN)-1:0]   rd_idx,
  output logic [$clog2(SIZE_X)-1:0]    rd_x,
  output logic [$clog2(SIZE_Y)-1:0]    rd_y,
  output logic                         rd_valid
);

  localparam int XW = $clog2(SIZE_X);
  localparam int YW = $clog2(SIZE_Y);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int PW = $clog2(MAX_LEN);

  localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_LEN);
  localparam logic [LW-1:0] LEN_INIT = LW'(INIT_LEN);
  localparam logic [PW-1:0] PTR_LAST = PW'(MAX_LEN - 1);
  localparam logic [PW:0]   PTR_MOD  = (PW+1)'(MAX_LEN);
  localparam logic [PW-1:0] INIT_END = PW'(INIT_LEN - 1);
  localparam logic [XW-1:0] X_MID    = XW'(SIZE_X / 2);
  localparam logic [YW-1:0] Y_MID    = YW'(SIZE_Y / 2);

  logic [XW-1:0] body_x [MAX_LEN];
  logic [YW-1:0] body_y [MAX_LEN];

  state_e        state;
  logic [PW-1:0] head_ptr, cnt;
  dir_e          dir_l;
  logic          grow_l;
  logic [XW-1:0] nx, nx_l, wr_x;
  logic [YW-1:0] ny, ny_l, wr_y;
  logic          oob, wr_en, hit;
  logic [PW-1:0] scan_ptr, rd_ptr, ptr_dec, wr_ptr;
  logic [LW-1:0] scan_lim;

  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] a, input logic [PW-1:0] b);
    logic [PW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= PTR_MOD) s = s - PTR_MOD;
    return s[PW-1:0];
  endfunction

  snake_next_head #(
    .SIZE_X(SIZE_X), .SIZE_Y(SIZE_Y), .WRAP(WRAP), .XW(XW), .YW(YW)
  ) u_next (
    .head_x(head_x), .head_y(head_y), .dir(dir_l),
    .next_x(nx), .next_y(ny), .oob(oob)
  );

  assign scan_ptr = ptr_add(head_ptr, cnt);
  assign rd_ptr   = ptr_add(head_ptr, rd_idx);
  assign ptr_dec  = (head_ptr == '0) ? PTR_LAST : head_ptr - PW'(1);
  // Without growth the tail cell is vacated by this move, so it is not scanned.
  assign scan_lim = grow_l ? length : length - LW'(1);
  assign hit      = (body_x[scan_ptr] == nx_l) && (body_y[scan_ptr] == ny_l);

  always_comb begin
    wr_en  = 1'b0;
    wr_ptr = cnt;
    wr_x   = X_MID - XW'(cnt);
    wr_y   = Y_MID;
    if (state == ST_INIT) begin
      wr_en = 1'b1;
    end else if (state == ST_UPDATE) begin
      wr_en  = 1'b1;
      wr_ptr = ptr_dec;
      wr_x   = nx_l;
      wr_y   = ny_l;
    end
  end

  // Segment store is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      body_x[wr_ptr] <= wr_x;
      body_y[wr_ptr] <= wr_y;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_INIT;
      head_ptr <= '0;
      cnt      <= '0;
      length   <= '0;
      busy     <= 1'b1;
      done     <= 1'b0;
      dead     <= 1'b0;
      cur_dir  <= DIR_RIGHT;
      head_x   <= '0;
      head_y   <= '0;
      dir_l    <= DIR_RIGHT;
      grow_l   <= 1'b0;
      nx_l     <= '0;
      ny_l     <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        state    <= ST_INIT;
        head_ptr <= '0;
        cnt      <= '0;
        length   <= '0;
        busy     <= 1'b1;
        dead     <= 1'b0;
        cur_dir  <= DIR_RIGHT;
      end else begin
        unique case (state)
          ST_INIT: begin
            if (cnt == '0) begin
              head_x <= X_MID;
              head_y <= Y_MID;
            end
            if (cnt == INIT_END) begin
              length <= LEN_INIT;
              cnt    <= '0;
              busy   <= 1'b0;
              state  <= ST_IDLE;
            end else cnt <= cnt + PW'(1);
          end
          ST_IDLE:
            if (step) begin
              dir_l  <= (dir_e'(dir) == rev_dir(dir_e'(cur_dir))) ? dir_e'(cur_dir) : dir_e'(dir);
              grow_l <= grow && (length < LEN_MAX);
              busy   <= 1'b1;
              state  <= ST_CALC;
            end
          ST_CALC:
            if (oob) begin
              dead  <= 1'b1;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_DEAD;
            end else begin
              nx_l  <= nx;
              ny_l  <= ny;
              cnt   <= '0;
              state <= ST_SCAN;
            end
          ST_SCAN:
            if (hit) begin
              dead  <= 1'b1;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_DEAD;
            end else if (LW'(cnt) == scan_lim - LW'(1)) begin
              state <= ST_UPDATE;
            end else cnt <= cnt + PW'(1);
          ST_UPDATE: begin
            head_ptr <= ptr_dec;
            head_x   <= nx_l;
            head_y   <= ny_l;
            cur_dir  <= dir_l;
            if (grow_l) length <= length + LW'(1);
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end
          ST_DEAD: state <= ST_DEAD;
          default: state <= ST_INIT;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_x     <= '0;
      rd_y     <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_x     <= body_x[rd_ptr];
      rd_y     <= body_y[rd_ptr];
      rd_valid <= LW'(rd_idx) < length;
    end
  end

endmodule

// File: tb/tb_snake_core.sv
// Bench for snake_core: directed table, corner sequences on WRAP=0 and
// MAX_LEN=4 instances, and random moves against a queue-based snake model.
module tb_snake_core;

  localparam int SX = 40;
  localparam int SY = 30;

  logic clk = 1'b0;
  logic rst, start, step, grow;
  logic [1:0] dir;
  logic [5:0] rd_idx;

  logic busy0, done0, dead0, rv0;  logic [6:0] len0; logic [5:0] hx0, rx0; logic [4:0] hy0, ry0; logic [1:0] cd0;
  logic busy1, done1, dead1, rv1;  logic [6:0] len1; logic [5:0] hx1, rx1; logic [4:0] hy1, ry1; logic [1:0] cd1;
  logic busy2, done2, dead2, rv2;  logic [2:0] len2; logic [5:0] hx2, rx2; logic [4:0] hy2, ry2; logic [1:0] cd2;

  always #5 clk = ~clk;

  snake_core #(.WRAP(1)) dut (
    .clk(clk), .rst(rst), .start(start), .step(step), .dir(dir), .grow(grow),
    .busy(busy0), .done(done0), .dead(dead0), .length(len0), .head_x(hx0), .head_y(hy0),
    .cur_dir(cd0), .rd_idx(rd_idx), .rd_x(rx0), .rd_y(ry0), .rd_valid(rv0));

  snake_core #(.WRAP(0)) dut_nw (
    .clk(clk), .rst(rst), .start(start), .step(step), .dir(dir), .grow(grow),
    .busy(busy1), .done(done1), .dead(dead1), .length(len1), .head_x(hx1), .head_y(hy1),
    .cur_dir(cd1), .rd_idx(rd_idx), .rd_x(rx1), .rd_y(ry1), .rd_valid(rv1));

  snake_core #(.MAX_LEN(4)) dut_m4 (
    .clk(clk), .rst(rst), .start(start), .step(step), .dir(dir), .grow(grow),
    .busy(busy2), .done(done2), .dead(dead2), .length(len2), .head_x(hx2), .head_y(hy2),
    .cur_dir(cd2), .rd_idx(rd_idx[1:0]), .rd_x(rx2), .rd_y(ry2), .rd_valid(rv2));

  typedef struct packed {int busy, done, dead, len, hx, hy, cdir, rx, ry, rv;} obs_t;
  obs_t ob0, ob1, ob2;
  always_comb ob0 = '{int'(busy0), int'(done0), int'(dead0), int'(len0), int'(hx0), int'(hy0), int'(cd0), int'(rx0), int'(ry0), int'(rv0)};
  always_comb ob1 = '{int'(busy1), int'(done1), int'(dead1), int'(len1), int'(hx1), int'(hy1), int'(cd1), int'(rx1), int'(ry1), int'(rv1)};
  always_comb ob2 = '{int'(busy2), int'(done2), int'(dead2), int'(len2), int'(hx2), int'(hy2), int'(cd2), int'(rx2), int'(ry2), int'(rv2)};

  function automatic obs_t get(input int sel);
    case (sel)
      0:       return ob0;
      1:       return ob1;
      default: return ob2;
    endcase
  endfunction

  int nchk = 0, nfail = 0;

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Snake model: queue of cells, head first.
  int mx[$], my[$];
  int mdir, mdead, mwrap, mmax;

  task automatic model_reset(input int w, input int m);
    mwrap = w; mmax = m;
    mx = {20, 19, 18}; my = {15, 15, 15};
    mdir = 1; mdead = 0;
  endtask

  // Returns the number of clock edges from step sampling to done.
  task automatic model_step(input int d, input int g, output int lat);
    int ed, nx, ny, gl, l;
    ed = (d == (mdir ^ 2)) ? mdir : d;
    nx = mx[0]; ny = my[0];
    case (ed)
      0: ny = ny - 1;
      1: nx = nx + 1;
      2: ny = ny + 1;
      default: nx = nx - 1;
    endcase
    if (nx < 0 || nx >= SX || ny < 0 || ny >= SY) begin
      if (mwrap == 0) begin mdead = 1; lat = 2; return; end
      nx = (nx + SX) % SX; ny = (ny + SY) % SY;
    end
    gl = (g != 0 && mx.size() < mmax) ? 1 : 0;
    l  = gl ? mx.size() : mx.size() - 1;
    for (int i = 0; i < l; i++)
      if (mx[i] == nx && my[i] == ny) begin mdead = 1; lat = i + 3; return; end
    mx.push_front(nx); my.push_front(ny);
    if (gl == 0) begin void'(mx.pop_back()); void'(my.pop_back()); end
    mdir = ed;
    lat  = l + 3;
  endtask

  task automatic check_state(input int sel, input string tag);
    obs_t o;
    o = get(sel);
    chk({tag, "_dead"}, o.dead, mdead);
    chk({tag, "_length"}, o.len, mx.size());
    chk({tag, "_head_x"}, o.hx, mx[0]);
    chk({tag, "_head_y"}, o.hy, my[0]);
    chk({tag, "_cur_dir"}, o.cdir, mdir);
    chk({tag, "_busy"}, o.busy, 0);
  endtask

  task automatic do_step(input int sel, input int d, input int g);
    int lat, n, hold;
    obs_t o;
    model_step(d, g, lat);
    hold = int'($urandom_range(0, 1));
    @(negedge clk); step = 1'b1; dir = 2'(d); grow = g[0];
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (!(hold == 1 && n == 1)) step = 1'b0;
      o = get(sel);
    end while (o.done == 0 && n < 200);
    step = 1'b0;
    chk("step_latency", n, lat);
    check_state(sel, "step");
  endtask

  task automatic chk_rd(input int sel, input int idx);
    obs_t o;
    int v;
    @(negedge clk); rd_idx = 6'(idx);
    @(posedge clk); #1;
    o = get(sel);
    v = (idx < mx.size()) ? 1 : 0;
    chk("rd_valid", o.rv, v);
    if (v == 1) begin
      chk("rd_x", o.rx, mx[idx]);
      chk("rd_y", o.ry, my[idx]);
    end
  endtask

  task automatic do_reset(input int sel, input int w, input int m);
    obs_t o;
    @(negedge clk); rst = 1'b1; step = 1'b0; start = 1'b0;
    @(posedge clk); @(negedge clk); rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_reset(w, m);
    o = get(sel);
    chk("init_busy", o.busy, 0);
    check_state(sel, "init");
  endtask

  task automatic do_start(input int sel);
    obs_t o;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    o = get(sel);
    chk("start_busy", o.busy, 1);
    chk("start_dead_clr", o.dead, 0);
    repeat (3) @(posedge clk);
    #1;
    model_reset(mwrap, mmax);
    check_state(sel, "restart");
  endtask

  typedef struct {int d, g, hx, hy, len, cdir, dead;} vec_t;
  vec_t tbl [7];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t o;
    int seen;

    tbl[0] = '{1, 0, 21, 15, 3, 1, 0};  // plain move right
    tbl[1] = '{3, 0, 22, 15, 3, 1, 0};  // reversal replaced by right
    tbl[2] = '{1, 1, 23, 15, 4, 1, 0};
    tbl[3] = '{1, 1, 24, 15, 5, 1, 0};
    tbl[4] = '{0, 0, 24, 14, 5, 0, 0};
    tbl[5] = '{3, 0, 23, 14, 5, 3, 0};
    tbl[6] = '{2, 0, 23, 14, 5, 3, 1};  // bites own body

    rst = 1'b1; start = 1'b0; step = 1'b0; dir = 2'd0; grow = 1'b0; rd_idx = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      o = get(s);
      chk("rst_busy", o.busy, 1);
      chk("rst_length", o.len, 0);
      chk("rst_done", o.done, 0);
      chk("rst_dead", o.dead, 0);
      chk("rst_cur_dir", o.cdir, 1);
      chk("rst_rd_valid", o.rv, 0);
    end
    @(negedge clk); rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_reset(1, 64);
    chk("init_busy", ob0.busy, 0);
    check_state(0, "init");
    for (int i = 0; i < 4; i++) chk_rd(0, i);

    for (int i = 0; i < 7; i++) begin
      do_step(0, tbl[i].d, tbl[i].g);
      o = get(0);
      chk("tbl_head_x", o.hx, tbl[i].hx);
      chk("tbl_head_y", o.hy, tbl[i].hy);
      chk("tbl_length", o.len, tbl[i].len);
      chk("tbl_cur_dir", o.cdir, tbl[i].cdir);
      chk("tbl_dead", o.dead, tbl[i].dead);
      if (i == 0) begin
        chk_rd(0, 2);
        chk("tbl_rd2_x", ob0.rx, 19);
      end
    end

    // Step while dead must be ignored.
    @(negedge clk); step = 1'b1; dir = 2'd1;
    @(posedge clk); #1; step = 1'b0;
    seen = 0;
    repeat (8) begin @(posedge clk); #1; if (ob0.done) seen++; end
    chk("dead_step_done", seen, 0);
    chk("dead_hold", ob0.dead, 1);
    chk("dead_head_x", ob0.hx, mx[0]);

    // start and step in the same cycle: step is dropped.
    @(negedge clk); start = 1'b1; step = 1'b1; dir = 2'd0;
    @(posedge clk); #1; start = 1'b0; step = 1'b0;
    chk("start_busy", ob0.busy, 1);
    chk("start_dead_clr", ob0.dead, 0);
    repeat (3) @(posedge clk);
    #1;
    model_reset(1, 64);
    check_state(0, "start");
    repeat (6) @(posedge clk);
    #1;
    chk("start_step_ignored_y", ob0.hy, 15);

    // Length-4 snake chasing its tail around a 2x2 square.
    do_step(0, 1, 1);
    for (int r = 0; r < 2; r++) begin
      do_step(0, 0, 0); do_step(0, 3, 0); do_step(0, 2, 0); do_step(0, 1, 0);
    end
    chk("loop_alive", ob0.dead, 0);

    // Edge behaviour without and with wrap.
    do_reset(1, 0, 64);
    for (int i = 0; i < 20; i++) do_step(1, 1, 0);
    chk("nowrap_dead", ob1.dead, 1);
    chk("nowrap_head_x", ob1.hx, 39);
    do_reset(0, 1, 64);
    for (int i = 0; i < 20; i++) do_step(0, 1, 0);
    chk("wrap_dead", ob0.dead, 0);
    chk("wrap_head_x", ob0.hx, 0);

    // Capacity limit, then abort a step mid-scan.
    do_reset(2, 1, 4);
    do_step(2, 1, 1);
    chk("m4_len_a", ob2.len, 4);
    do_step(2, 1, 1);
    chk("m4_len_b", ob2.len, 4);
    chk_rd(2, 3);
    @(negedge clk); step = 1'b1; dir = 2'd2; grow = 1'b0;
    @(posedge clk); #1; step = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("m4_scan_busy", ob2.busy, 1);
    do_start(2);
    chk("m4_restart_len", ob2.len, 3);

    // Random moves against the model.
    do_reset(0, 1, 64);
    for (int k = 0; k < 300; k++) begin
      if (mdead != 0) do_start(0);
      do_step(0, int'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0) ? 1 : 0);
      if (mdead == 0) chk_rd(0, int'($urandom_range(0, 63)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
